// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: port 0 (MEM stage) has priority,
// port 1 (debug/loader) gets a forced grant after MAX_WAIT denials; accept -> access -> response.
module dmem_arbiter #(
  parameter int AW        = 64,
  parameter int DW        = 64,
  parameter int MEM_BYTES = 65536,
  parameter int MAX_WAIT  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_adr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_adr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_din,
  output logic          mem_mrd,
  output logic          mem_mwr,
  input  logic [DW-1:0] mem_dout
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
  // Highest legal start address; comparing against it avoids overflow of adr + 7.
  localparam logic [AW-1:0] LAST_ADR = AW'(MEM_BYTES - 8);

  logic [CW-1:0] wait_q, wait_d;
  logic          force_p1;

  logic          acc_vld_q, acc_vld_d;
  logic          acc_port_q, acc_port_d;
  logic          acc_we_q, acc_we_d;
  logic          acc_legal_q, acc_legal_d;
  logic [AW-1:0] acc_adr_q, acc_adr_d;
  logic [DW-1:0] acc_wdata_q, acc_wdata_d;

  logic          p0_rvalid_q, p0_rvalid_d, p0_err_q, p0_err_d;
  logic          p1_rvalid_q, p1_rvalid_d, p1_err_q, p1_err_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

  logic          mem_go;
  logic          rsp_fire;

  always_comb begin
    force_p1 = p1_req && (wait_q == WAIT_MAX);
    // Grants are gated by rst_n so nothing is accepted while reset is held.
    p1_gnt   = rst_n && p1_req && (!p0_req || force_p1);
    p0_gnt   = rst_n && p0_req && !force_p1;
    wait_d   = wait_q;
    if (!p1_req || p1_gnt) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_comb begin
    acc_vld_d   = p0_gnt || p1_gnt;
    acc_port_d  = p1_gnt;
    acc_we_d    = p1_gnt ? p1_we    : p0_we;
    acc_adr_d   = p1_gnt ? p1_adr   : p0_adr;
    acc_wdata_d = p1_gnt ? p1_wdata : p0_wdata;
    acc_legal_d = acc_adr_d <= LAST_ADR;
  end

  always_comb begin
    mem_go  = acc_vld_q && acc_legal_q;
    mem_mrd = mem_go && !acc_we_q;
    mem_mwr = mem_go && acc_we_q;
    mem_adr = mem_go ? acc_adr_q : '0;
    mem_din = (mem_go && acc_we_q) ? acc_wdata_q : '0;
  end

  // Reads and illegal accesses of either kind produce a response; legal writes are silent.
  always_comb begin
    rsp_fire    = acc_vld_q && (!acc_legal_q || !acc_we_q);
    p0_rvalid_d = rsp_fire && !acc_port_q;
    p1_rvalid_d = rsp_fire && acc_port_q;
    p0_err_d    = p0_rvalid_d && !acc_legal_q;
    p1_err_d    = p1_rvalid_d && !acc_legal_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    if (p0_rvalid_d) p0_rdata_d = acc_legal_q ? mem_dout : '0;
    if (p1_rvalid_d) p1_rdata_d = acc_legal_q ? mem_dout : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q      <= '0;
      acc_vld_q   <= 1'b0;
      acc_port_q  <= 1'b0;
      acc_we_q    <= 1'b0;
      acc_legal_q <= 1'b0;
      acc_adr_q   <= '0;
      acc_wdata_q <= '0;
      p0_rvalid_q <= 1'b0;
      p0_err_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rvalid_q <= 1'b0;
      p1_err_q    <= 1'b0;
      p1_rdata_q  <= '0;
    end else begin
      wait_q      <= wait_d;
      acc_vld_q   <= acc_vld_d;
      acc_port_q  <= acc_port_d;
      acc_we_q    <= acc_we_d;
      acc_legal_q <= acc_legal_d;
      acc_adr_q   <= acc_adr_d;
      acc_wdata_q <= acc_wdata_d;
      p0_rvalid_q <= p0_rvalid_d;
      p0_err_q    <= p0_err_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rvalid_q <= p1_rvalid_d;
      p1_err_q    <= p1_err_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p0_err    = p0_err_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p1_err    = p1_err_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run scored against a
// cycle-stamped command queue and a model memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [63:0] p0_adr = '0, p0_wdata = '0, p1_adr = '0, p1_wdata = '0;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [63:0] p0_rdata, p1_rdata;
  logic [63:0] mem_adr, mem_din, mem_dout;
  logic        mem_mrd, mem_mwr;

  int errors = 0;
  int checks = 0;

  logic [63:0] tb_mem  [0:8191];
  logic [63:0] ref_mem [0:8191];
  logic        mem_load = 1'b0;
  logic [31:0] mem_salt = '0;

  typedef struct {
    int          cyc;
    bit          port;
    bit          we;
    bit          legal;
    logic [63:0] adr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } cmd_t;
  cmd_t q[$];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_adr(p0_adr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_adr(p1_adr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_adr(mem_adr), .mem_din(mem_din), .mem_mrd(mem_mrd), .mem_mwr(mem_mwr),
    .mem_dout(mem_dout)
  );

  function automatic logic [63:0] pat(input int idx, input logic [31:0] salt);
    if (salt == 0 && idx == 250) return 64'h11;
    return {salt ^ 32'hA5A5_0000, 32'(idx) * 32'd7 + 32'd3};
  endfunction

  // Memory model: combinational read, write committed at the end of the access cycle.
  always_comb mem_dout = tb_mem[mem_adr[15:3]];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 8192; i++) tb_mem[i] <= pat(i, mem_salt);
    end else if (mem_mwr) begin
      tb_mem[mem_adr[15:3]] <= mem_din;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; mem_salt = 0; mem_load = 1;
    p0_req = 1; p1_req = 1; p0_adr = 64'd2000; p1_adr = 64'd2008;
    tick(); mem_load = 0; tick(); #1;
    checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got=%b%b exp=00", p0_gnt, p1_gnt); end
    checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || p0_err !== 1'b0 || p1_err !== 1'b0) begin errors++; $display("FAIL rst_rvalid_err got=%b%b%b%b exp=0000", p0_rvalid, p1_rvalid, p0_err, p1_err); end
    checks++; if (mem_mrd !== 1'b0 || mem_mwr !== 1'b0 || mem_adr !== 64'd0 || mem_din !== 64'd0) begin errors++; $display("FAIL rst_mem got mrd=%b mwr=%b adr=%h din=%h exp=0", mem_mrd, mem_mwr, mem_adr, mem_din); end
    checks++; if (p0_rdata !== 64'd0 || p1_rdata !== 64'd0) begin errors++; $display("FAIL rst_rdata got=%h/%h exp=0", p0_rdata, p1_rdata); end
    tick(); rst_n = 1; idle();
    tick();
    p0_req = 1; p0_we = 0; p0_adr = 64'd2000; #1;
    checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin errors++; $display("FAIL first_gnt got=%b%b exp=10", p0_gnt, p1_gnt); end
    tick(); idle();
    checks++; if (mem_mrd !== 1'b1 || mem_mwr !== 1'b0 || mem_adr !== 64'd2000) begin errors++; $display("FAIL first_access got mrd=%b mwr=%b adr=%0d exp 1,0,2000", mem_mrd, mem_mwr, mem_adr); end
    tick();
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 64'h11 || p0_err !== 1'b0 || p1_rvalid !== 1'b0) begin errors++; $display("FAIL first_rsp got rv=%b data=%h err=%b p1rv=%b exp 1,11,0,0", p0_rvalid, p0_rdata, p0_err, p1_rvalid); end
    tick();
    checks++; if (p0_rvalid !== 1'b0 || p0_rdata !== 64'h11) begin errors++; $display("FAIL rdata_hold got rv=%b data=%h exp 0,11", p0_rvalid, p0_rdata); end
  endtask

  task automatic test_write_read();
    tick();
    p0_req = 1; p0_we = 1; p0_adr = 64'd1000; p0_wdata = 64'hDEAD_BEEF; #1;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt got=%b exp=1", p0_gnt); end
    tick();
    checks++; if (mem_mwr !== 1'b1 || mem_mrd !== 1'b0 || mem_adr !== 64'd1000 || mem_din !== 64'hDEAD_BEEF) begin errors++; $display("FAIL wr_access got mwr=%b mrd=%b adr=%0d din=%h", mem_mwr, mem_mrd, mem_adr, mem_din); end
    p0_we = 0; p0_wdata = 0; #1;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt got=%b exp=1", p0_gnt); end
    tick(); idle();
    checks++; if (mem_mrd !== 1'b1 || mem_mwr !== 1'b0 || mem_adr !== 64'd1000) begin errors++; $display("FAIL raw_access got mrd=%b mwr=%b adr=%0d", mem_mrd, mem_mwr, mem_adr); end
    checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got=%b exp=0", p0_rvalid); end
    tick();
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 64'hDEAD_BEEF || p0_err !== 1'b0) begin errors++; $display("FAIL raw_rsp got rv=%b data=%h err=%b exp 1,deadbeef,0", p0_rvalid, p0_rdata, p0_err); end
    tick();
  endtask

  task automatic test_starvation();
    p0_req = 1; p0_we = 0; p0_adr = 64'd4096;
    p1_req = 1; p1_we = 0; p1_adr = 64'd4104;
    for (int i = 0; i < 15; i++) begin
      #1;
      checks++;
      if (p1_gnt !== (i % 5 == 4) || p0_gnt !== (i % 5 != 4)) begin
        errors++; $display("FAIL starve_cycle%0d got p0=%b p1=%b exp p1=%0d", i, p0_gnt, p1_gnt, (i % 5 == 4));
      end
      tick();
    end
    idle();
    repeat (3) tick();
  endtask

  task automatic test_p1_alone();
    p1_req = 1; p1_we = 0; p1_adr = 64'd2008; #1;
    checks++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin errors++; $display("FAIL p1_gnt got p0=%b p1=%b exp 0,1", p0_gnt, p1_gnt); end
    tick(); idle();
    checks++; if (mem_mrd !== 1'b1 || mem_adr !== 64'd2008) begin errors++; $display("FAIL p1_access got mrd=%b adr=%0d exp 1,2008", mem_mrd, mem_adr); end
    tick();
    checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== pat(251, 0) || p0_rvalid !== 1'b0) begin errors++; $display("FAIL p1_rsp got rv=%b data=%h p0rv=%b exp 1,%h,0", p1_rvalid, p1_rdata, p0_rvalid, pat(251, 0)); end
    tick();
  endtask

  task automatic test_boundary();
    p1_req = 1; p1_we = 1; p1_adr = 64'd65528; p1_wdata = 64'hCAFE; #1;
    checks++; if (p1_gnt !== 1'b1) begin errors++; $display("FAIL bnd_gnt got=%b exp=1", p1_gnt); end
    tick();
    p1_adr = 64'd65529;
    checks++; if (mem_mwr !== 1'b1 || mem_adr !== 64'd65528 || mem_din !== 64'hCAFE) begin errors++; $display("FAIL bnd_legal got mwr=%b adr=%0d din=%h", mem_mwr, mem_adr, mem_din); end
    tick();
    p1_req = 0; p0_req = 1; p0_we = 0; p0_adr = 64'hFFFF_FFFF_FFFF_FFFC;
    checks++; if (p1_rvalid !== 1'b0) begin errors++; $display("FAIL bnd_legal_rv got=%b exp=0", p1_rvalid); end
    checks++; if (mem_mwr !== 1'b0 || mem_mrd !== 1'b0 || mem_adr !== 64'd0) begin errors++; $display("FAIL bnd_illegal_access got mwr=%b mrd=%b adr=%h", mem_mwr, mem_mrd, mem_adr); end
    tick(); idle();
    checks++; if (p1_rvalid !== 1'b1 || p1_err !== 1'b1 || p1_rdata !== 64'd0 || p0_rvalid !== 1'b0) begin errors++; $display("FAIL bnd_err_rsp got rv=%b err=%b data=%h p0rv=%b", p1_rvalid, p1_err, p1_rdata, p0_rvalid); end
    checks++; if (mem_mrd !== 1'b0) begin errors++; $display("FAIL wrap_access got mrd=%b exp=0", mem_mrd); end
    tick();
    checks++; if (p0_rvalid !== 1'b1 || p0_err !== 1'b1 || p0_rdata !== 64'd0 || p1_err !== 1'b0) begin errors++; $display("FAIL wrap_err_rsp got rv=%b err=%b data=%h p1err=%b", p0_rvalid, p0_err, p0_rdata, p1_err); end
    tick();
  endtask

  task automatic test_reset_midop();
    p0_req = 1; p0_we = 1; p0_adr = 64'd1000; p0_wdata = 64'h1234; #1;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL midop_gnt got=%b exp=1", p0_gnt); end
    @(negedge clk); rst_n = 0; #1;
    checks++; if (p0_gnt !== 1'b0 || mem_mwr !== 1'b0 || p0_rvalid !== 1'b0 || p0_rdata !== 64'd0) begin errors++; $display("FAIL midop_outputs got gnt=%b mwr=%b rv=%b data=%h", p0_gnt, mem_mwr, p0_rvalid, p0_rdata); end
    tick(); idle(); tick(); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (mem_mwr !== 1'b0 || p0_rvalid !== 1'b0) begin errors++; $display("FAIL midop_after%0d got mwr=%b rv=%b exp 0,0", i, mem_mwr, p0_rvalid); end
    end
    checks++; if (tb_mem[125] !== 64'hDEAD_BEEF) begin errors++; $display("FAIL midop_mem got=%h exp=deadbeef", tb_mem[125]); end
  endtask

  task automatic test_random();
    int          waited;
    bit          e_rv0, e_rv1, e_err, e_mrd, e_mwr, g0, g1;
    logic [63:0] e_data, e_adr, e_din, a;
    int          r;
    cmd_t        t;
    mem_salt = 32'h5A; mem_load = 1; tick(); mem_load = 0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = pat(i, 32'h5A);
    waited = 0;
    for (int c = 0; c < 402; c++) begin
      if (c > 0) tick();
      e_rv0 = 0; e_rv1 = 0; e_err = 0; e_data = '0;
      if (q.size() > 0 && q[0].cyc == c - 2) begin
        t = q.pop_front();
        if (!t.legal || !t.we) begin
          if (t.port) e_rv1 = 1; else e_rv0 = 1;
          e_err  = !t.legal;
          e_data = t.legal ? t.rdata : 64'd0;
        end
      end
      checks++;
      if (p0_rvalid !== e_rv0 || p1_rvalid !== e_rv1) begin errors++; $display("FAIL rnd_rvalid c=%0d got=%b%b exp=%b%b", c, p0_rvalid, p1_rvalid, e_rv0, e_rv1); end
      else if (e_rv0 && (p0_rdata !== e_data || p0_err !== e_err)) begin errors++; $display("FAIL rnd_p0_rsp c=%0d got %h/%b exp %h/%b", c, p0_rdata, p0_err, e_data, e_err); end
      else if (e_rv1 && (p1_rdata !== e_data || p1_err !== e_err)) begin errors++; $display("FAIL rnd_p1_rsp c=%0d got %h/%b exp %h/%b", c, p1_rdata, p1_err, e_data, e_err); end
      else if ((!e_rv0 && p0_err !== 1'b0) || (!e_rv1 && p1_err !== 1'b0)) begin errors++; $display("FAIL rnd_err_idle c=%0d got %b%b exp 00", c, p0_err, p1_err); end
      e_mrd = 0; e_mwr = 0; e_adr = '0; e_din = '0;
      foreach (q[i]) begin
        if (q[i].cyc == c - 1 && q[i].legal) begin
          t = q[i];
          e_adr = t.adr;
          if (t.we) begin
            e_mwr = 1; e_din = t.wdata; ref_mem[t.adr[15:3]] = t.wdata;
          end else begin
            e_mrd = 1; t.rdata = ref_mem[t.adr[15:3]]; q[i] = t;
          end
        end
      end
      checks++;
      if (mem_mrd !== e_mrd || mem_mwr !== e_mwr || mem_adr !== e_adr || mem_din !== e_din) begin
        errors++; $display("FAIL rnd_access c=%0d got mrd=%b mwr=%b adr=%h din=%h exp %b %b %h %h", c, mem_mrd, mem_mwr, mem_adr, mem_din, e_mrd, e_mwr, e_adr, e_din);
      end
      if (c < 400) begin
        p0_req = ($urandom_range(0, 99) < 65); p1_req = ($urandom_range(0, 99) < 55);
        p0_we = $urandom_range(0, 1) == 1; p1_we = $urandom_range(0, 1) == 1;
        p0_wdata = {$urandom, $urandom}; p1_wdata = {$urandom, $urandom};
        for (int k = 0; k < 2; k++) begin
          r = $urandom_range(0, 11);
          if (r == 0)      a = 64'd65528;
          else if (r == 1) a = 64'd65529 + 64'($urandom_range(0, 7));
          else if (r == 2) a = 64'hFFFF_FFFF_FFFF_FFF8;
          else             a = 64'd4096 + 64'd8 * 64'($urandom_range(0, 15));
          if (k == 0) p0_adr = a; else p1_adr = a;
        end
      end else begin
        idle();
      end
      #1;
      g1 = p1_req && (!p0_req || waited >= 4);
      g0 = p0_req && !g1;
      checks++;
      if (p0_gnt !== g0 || p1_gnt !== g1) begin errors++; $display("FAIL rnd_gnt c=%0d got=%b%b exp=%b%b", c, p0_gnt, p1_gnt, g0, g1); end
      waited = (p1_req && !g1) ? ((waited < 4) ? waited + 1 : 4) : 0;
      if (g0 || g1) begin
        t.cyc = c; t.port = g1; t.we = g1 ? p1_we : p0_we;
        t.adr = g1 ? p1_adr : p0_adr; t.wdata = g1 ? p1_wdata : p0_wdata;
        t.legal = t.adr <= 64'd65528; t.rdata = '0;
        q.push_back(t);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_starvation();
    test_p1_alone();
    test_boundary();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
